// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state encoding, counter sizing helpers and
// default period constants used by the alarm sounder and the rest of the clock.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEEP_ON,
        ST_BEEP_OFF,
        ST_GAP,
        ST_SNOOZE,
        ST_DONE
    } alarm_state_e;

    localparam int DEF_ON_CYCLES      = 25_000_000;
    localparam int DEF_OFF_CYCLES     = 25_000_000;
    localparam int DEF_BEEPS          = 4;
    localparam int DEF_GAP_CYCLES     = 100_000_000;
    localparam int DEF_SNOOZE_CYCLES  = 300_000_000;
    localparam int DEF_MAX_SNOOZE     = 3;
    localparam int DEF_TIMEOUT_GROUPS = 60;

    // Width able to hold 0..n; never narrower than one bit so a zero-valued
    // limit (e.g. snooze disabled) still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_sounder_if.sv
// Request/response bundle between the alarm-compare logic and the sounder.
interface alarm_sounder_if;

    logic i_Alarm_On;
    logic i_Snooze;
    logic i_Stop;
    logic o_Alarm_Out;
    logic o_Active;
    logic o_Snoozed;

    modport master (
        output i_Alarm_On, i_Snooze, i_Stop,
        input  o_Alarm_Out, o_Active, o_Snoozed
    );

    modport slave (
        input  i_Alarm_On, i_Snooze, i_Stop,
        output o_Alarm_Out, o_Active, o_Snoozed
    );

endinterface

// File: rtl/alarm_period_counter.sv
// Loadable down-counter timing each sounder state dwell; done pulses for one
// cycle when a loaded count of N-1 has run down, i.e. after exactly N cycles.
module alarm_period_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         armed;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) armed <= 1'b0;
            else           cnt   <= cnt - W'(1);
        end
    end

    assign done = armed && (cnt == '0);

endmodule

// File: rtl/alarm_sounder.sv
// Alarm burst pattern generator with bounded snooze and latched stop.
// Define ALARM_TIMEOUT_EN to auto-silence after TIMEOUT_GROUPS groups.
module alarm_sounder
    import alarm_pkg::*;
#(
    parameter int ON_CYCLES      = DEF_ON_CYCLES,
    parameter int OFF_CYCLES     = DEF_OFF_CYCLES,
    parameter int BEEPS          = DEF_BEEPS,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int SNOOZE_CYCLES  = DEF_SNOOZE_CYCLES,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE,
    parameter int TIMEOUT_GROUPS = DEF_TIMEOUT_GROUPS
) (
    input  logic           i_Clk,
    input  logic           i_Rst_L,
    alarm_sounder_if.slave bus
);

    localparam int MAX_P = max2(max2(ON_CYCLES, OFF_CYCLES), max2(GAP_CYCLES, SNOOZE_CYCLES));
    localparam int PW    = cnt_w(MAX_P);
    localparam int BW    = cnt_w(BEEPS);
    localparam int SW    = cnt_w(MAX_SNOOZE);

    localparam logic [PW-1:0] LD_ON    = PW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] LD_OFF   = PW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] LD_GAP   = PW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] LD_SNZ   = PW'(SNOOZE_CYCLES - 1);
    localparam logic [BW-1:0] BEEPS_V  = BW'(BEEPS);
    localparam logic [SW-1:0] MAXSNZ_V = SW'(MAX_SNOOZE);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 || BEEPS < 1 || GAP_CYCLES < 1 ||
        SNOOZE_CYCLES < 1 || MAX_SNOOZE < 0 || TIMEOUT_GROUPS < 1) begin : g_param_chk
        $error("alarm_sounder: illegal period/count parameter");
    end

    alarm_state_e  state, state_n;
    logic [BW-1:0] beep_cnt, beep_n;
    logic [SW-1:0] snz_cnt, snz_n;
    logic [PW-1:0] load_val;
    logic          period_done;
    logic          snooze_ok;
    logic          alarm_out_q, active_q, snoozed_q;

`ifdef ALARM_TIMEOUT_EN
    localparam int            GW   = cnt_w(TIMEOUT_GROUPS);
    localparam logic [GW-1:0] TG_V = GW'(TIMEOUT_GROUPS);
    logic [GW-1:0] grp_cnt, grp_n, grp_inc;

    assign grp_inc = (grp_cnt == TG_V) ? grp_cnt : grp_cnt + GW'(1);
`endif

    assign snooze_ok = bus.i_Snooze && (snz_cnt < MAXSNZ_V);

    always_comb begin
        state_n = state;
        beep_n  = beep_cnt;
        snz_n   = snz_cnt;
`ifdef ALARM_TIMEOUT_EN
        grp_n   = grp_cnt;
`endif
        if (!bus.i_Alarm_On) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_BEEP_ON;
                    beep_n  = BW'(1);
                    snz_n   = '0;
`ifdef ALARM_TIMEOUT_EN
                    grp_n   = '0;
`endif
                end
                ST_BEEP_ON, ST_BEEP_OFF, ST_GAP: begin
                    if (bus.i_Stop) begin
                        state_n = ST_DONE;
                    end else if (snooze_ok) begin
                        state_n = ST_SNOOZE;
                        snz_n   = snz_cnt + SW'(1);
`ifdef ALARM_TIMEOUT_EN
                        grp_n   = '0;
`endif
                    end else if (period_done) begin
                        if (state == ST_BEEP_ON) begin
                            state_n = ST_BEEP_OFF;
                        end else if (state == ST_BEEP_OFF) begin
                            if (beep_cnt < BEEPS_V) begin
                                state_n = ST_BEEP_ON;
                                beep_n  = beep_cnt + BW'(1);
                            end else begin
                                state_n = ST_GAP;
                            end
                        end else begin
                            beep_n = BW'(1);
`ifdef ALARM_TIMEOUT_EN
                            grp_n   = grp_inc;
                            state_n = (grp_inc == TG_V) ? ST_DONE : ST_BEEP_ON;
`else
                            state_n = ST_BEEP_ON;
`endif
                        end
                    end
                end
                ST_SNOOZE: begin
                    // Further snooze pulses are ignored here, so the dwell never stretches.
                    if (bus.i_Stop) begin
                        state_n = ST_DONE;
                    end else if (period_done) begin
                        state_n = ST_BEEP_ON;
                        beep_n  = BW'(1);
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_comb begin
        case (state_n)
            ST_BEEP_ON:  load_val = LD_ON;
            ST_BEEP_OFF: load_val = LD_OFF;
            ST_GAP:      load_val = LD_GAP;
            ST_SNOOZE:   load_val = LD_SNZ;
            default:     load_val = '0;
        endcase
    end

    alarm_period_counter #(.W(PW)) u_period (
        .clk      (i_Clk),
        .rst_l    (i_Rst_L),
        .load     (state_n != state),
        .load_val (load_val),
        .done     (period_done)
    );

    // Outputs are registered from the next state so they match the state register exactly.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state       <= ST_IDLE;
            beep_cnt    <= '0;
            snz_cnt     <= '0;
            alarm_out_q <= 1'b0;
            active_q    <= 1'b0;
            snoozed_q   <= 1'b0;
        end else begin
            state       <= state_n;
            beep_cnt    <= beep_n;
            snz_cnt     <= snz_n;
            alarm_out_q <= (state_n == ST_BEEP_ON);
            active_q    <= (state_n == ST_BEEP_ON) || (state_n == ST_BEEP_OFF) ||
                           (state_n == ST_GAP) || (state_n == ST_SNOOZE);
            snoozed_q   <= (state_n == ST_SNOOZE);
        end
    end

`ifdef ALARM_TIMEOUT_EN
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) grp_cnt <= '0;
        else          grp_cnt <= grp_n;
    end
`endif

    assign bus.o_Alarm_Out = alarm_out_q;
    assign bus.o_Active    = active_q;
    assign bus.o_Snoozed   = snoozed_q;

endmodule

// File: tb/tb_alarm_sounder.sv
// Bench for alarm_sounder: vector table, corner-case sequences and random
// stimulus against a cycle-position reference model of the burst pattern.
module tb_alarm_sounder;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int BPS  = 2;
    localparam int GAP  = 4;
    localparam int SNZ  = 10;
    localparam int MAXS = 1;
    localparam int TG   = 2;
    localparam int GRP  = BPS * (ON + OFF) + GAP;

    // Output words are {o_Alarm_Out, o_Active, o_Snoozed}.
    localparam int Z  = 0;
    localparam int BP = 6;
    localparam int SL = 2;
    localparam int SN = 3;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alarm_sounder_if bus ();

    alarm_sounder #(
        .ON_CYCLES(ON), .OFF_CYCLES(OFF), .BEEPS(BPS), .GAP_CYCLES(GAP),
        .SNOOZE_CYCLES(SNZ), .MAX_SNOOZE(MAXS), .TIMEOUT_GROUPS(TG)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 patterning, 2 snoozing, 3 stopped.
    int m_mode = 0, m_t = 0, m_st = 0, m_snz = 0, m_grp = 0;

    function automatic int model_out();
        int pos;
        pos = m_t % GRP;
        if (m_mode == 1) return ((pos < BPS * (ON + OFF)) && ((pos % (ON + OFF)) < ON)) ? BP : SL;
        if (m_mode == 2) return SN;
        return Z;
    endfunction

    task automatic model_step(input bit r, input bit on, input bit s, input bit p);
        if (!r) begin
            m_mode = 0; m_t = 0; m_st = 0; m_snz = 0; m_grp = 0;
        end else if (!on) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_t = 0; m_snz = 0; m_grp = 0; end
                1: begin
                    if (p) m_mode = 3;
                    else if (s && m_snz < MAXS) begin
                        m_mode = 2; m_st = 0; m_snz++; m_grp = 0;
                    end else begin
                        m_t++;
                        if (m_t % GRP == 0) begin
                            m_grp++;
`ifdef ALARM_TIMEOUT_EN
                            if (m_grp >= TG) m_mode = 3;
`endif
                        end
                    end
                end
                2: begin
                    if (p) m_mode = 3;
                    else begin
                        m_st++;
                        if (m_st == SNZ) begin m_mode = 1; m_t = 0; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive, clock, advance the model, then sample and compare.
    task automatic cyc(input bit r, input bit on, input bit s, input bit p, output int got);
        rst_l          = r;
        bus.i_Alarm_On = on;
        bus.i_Snooze   = s;
        bus.i_Stop     = p;
        @(posedge clk);
        model_step(r, on, s, p);
        #1;
        got = 32'({bus.o_Alarm_Out, bus.o_Active, bus.o_Snoozed});
        check("model", got, model_out());
    endtask

    typedef struct {
        bit r;
        bit on;
        bit s;
        bit p;
        int exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int got;
        int cnt;
        logic [13:0] pat;

        bus.i_Alarm_On = 1'b0;
        bus.i_Snooze   = 1'b0;
        bus.i_Stop     = 1'b0;

        // Table: reset, idle, then two full groups of the basic pattern.
        pat = 14'b11100111000000;
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, Z});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, Z});
        for (int i = 0; i < 2 * GRP; i++)
            vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, pat[13 - (i % GRP)] ? BP : SL});
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].on, vecs[i].s, vecs[i].p, got);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

`ifdef ALARM_TIMEOUT_EN
        cyc(1, 1, 0, 0, got);
        check("timeout_done", got, Z);
`else
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1, 1, 0, 0, got);
            if (got != Z) cnt++;
        end
        check("persist_active", cnt, 200);
`endif

        // Snooze in the 2nd beep, exact dwell, fresh beep, second snooze ignored.
        cyc(0, 0, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, got);
        cyc(1, 1, 1, 0, got);
        check("snooze_enter", got, SN);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 0, 0, got);
            if (got == SN) cnt++;
        end
        check("snooze_dwell", cnt, 9);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, got);
            check("post_snooze_beep", got, BP);
        end
        cyc(1, 1, 1, 0, got);
        check("snooze2_ignored", got, SL);

        // Stop mid-beep with request held, then re-arm via drop/raise.
        cyc(0, 0, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        cyc(1, 1, 0, 1, got);
        check("stop", got, Z);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1, 1, 0, 0, got);
            if (got != Z) cnt++;
        end
        check("done_hold50", cnt, 0);
        cyc(1, 0, 0, 0, got);
        check("drop_idle", got, Z);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, got);
            check("restart_beep", got, BP);
        end
        cyc(1, 1, 0, 0, got);
        check("restart_off", got, SL);

        // Request drop during snooze; stop beats a simultaneous snooze.
        cyc(0, 0, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        cyc(1, 1, 1, 0, got);
        check("snooze_again", got, SN);
        cyc(1, 0, 0, 0, got);
        check("drop_in_snooze", got, Z);
        cyc(1, 1, 0, 0, got);
        check("rearm", got, BP);
        cyc(1, 1, 1, 1, got);
        check("stop_over_snooze", got, Z);
        cyc(1, 1, 0, 0, got);
        check("stop_latched", got, Z);

        // One-cycle reset mid beep, then a full-length beep.
        cyc(1, 0, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        cyc(1, 1, 0, 0, got);
        cyc(0, 1, 0, 0, got);
        check("reset_mid", got, Z);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, got);
            check("reset_restart_beep", got, BP);
        end
        cyc(1, 1, 0, 0, got);
        check("reset_restart_off", got, SL);

        // Random traffic against the model.
        begin
            bit on_r;
            on_r = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 39) == 0) on_r = ~on_r;
                cyc($urandom_range(0, 99) != 0, on_r,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0, got);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
